seq_stage_controller: RTL and testbench
=======================================

Name: seq_stage_controller

Overview:
- Control FSM for the sequential RV64 core; sequences one instruction at a time through fetch, decode, execute, memory, writeback and PC update.
- Consumes the fetch stage status (`instr_valid`, `imem_error`, `opcode`, `branch_taken`) and the data-memory handshake.
- Drives per-stage enables, the PC write strobe and PC-source select, plus processor status and performance counters.

Parameters:
- `MEM_TIMEOUT`, 15: max cycles `mem_req` may wait for `dmem_ready` before an ADR fault.
- `CNT_W`, 32: width of the retired-instruction and cycle counters.

Ports:
- `clk` input 1: core clock; all state changes on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: leave IDLE and begin execution.
- `single_step` input 1: return to IDLE after each retired instruction.
- `instr_valid` input 1: fetch decoded a legal instruction.
- `imem_error` input 1: fetch PC out of instruction memory range.
- `opcode` input 7: opcode from fetch.
- `branch_taken` input 1: execute resolved a taken branch/jump.
- `dmem_ready` input 1: data memory completes the current access.
- `dmem_error` input 1: data memory access fault; qualified by `dmem_ready`.
- `fetch_en`, `decode_en`, `exec_en`, `wb_en` output 1 each: stage enables.
- `mem_req` output 1: data memory request, held until ready.
- `pc_we` output 1: PC register write strobe.
- `pc_sel` output 1: 0 selects `nextp`, 1 selects `branch_target`.
- `busy` output 1: high in any state except IDLE, HALT, ERROR.
- `stat` output 2: 00 AOK, 01 HLT, 10 ADR, 11 INS.
- `retired` output `CNT_W`: retired-instruction count.
- `cycles` output `CNT_W`: cycles spent with `busy`=1.

Behaviour:
- **Reset.** State IDLE; all enables, `mem_req`, `pc_we`, `pc_sel` are 0; `stat`=00; counters 0; wait counter 0. Reset overrides every state, including mid-MEMORY: `mem_req` drops the next cycle.
- **Outputs.** All outputs are registered state decodes. Each enable is high for exactly one cycle per visit to its state; `mem_req` stays high for every MEMORY cycle.
- **IDLE.**
  - `start`=1 → FETCH.
  - Otherwise stay.
- **FETCH** (`fetch_en`):
  - `imem_error` → ERROR, `stat`=ADR. `imem_error` has priority over `instr_valid`.
  - else `instr_valid`=0 → ERROR, `stat`=INS.
  - else → DECODE.
- **DECODE** (`decode_en`):
  - Latch the opcode class: LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, SYSTEM 1110011, other = ALU (includes LUI and AUIPC).
  - SYSTEM → HALT, `stat`=HLT, not counted as retired.
  - Otherwise → EXECUTE.
- **EXECUTE** (`exec_en`):
  - Latch `pc_sel` ← `branch_taken` for BRANCH/JAL/JALR; 0 for all other classes.
  - LOAD/STORE → MEMORY.
  - BRANCH → PCUPD.
  - else → WB.
- **MEMORY** (`mem_req`):
  - Each cycle without `dmem_ready`, the wait counter increments.
  - `dmem_ready`&`dmem_error` → ERROR, `stat`=ADR.
  - `dmem_ready` → WB for LOAD, PCUPD for STORE; clear the wait counter.
  - Wait counter reaches `MEM_TIMEOUT` with no ready → ERROR, `stat`=ADR.
  - `dmem_ready` on the same cycle the counter hits the limit is accepted (ready wins).
- **WB** (`wb_en`): → PCUPD.
- **PCUPD** (`pc_we`, `pc_sel` held):
  - `retired`++ (wraps at 2^`CNT_W`).
  - `pc_sel` clears on exit.
  - `single_step` → IDLE, else → FETCH.
- **HALT / ERROR.** Sticky until `rst`; `start` is ignored. `stat` holds its value.
- **Latencies** (cycles, FETCH to PCUPD inclusive):
  - ALU/JAL/JALR: 5.
  - BRANCH: 4.
  - STORE: 5+w.
  - LOAD: 6+w, where w = MEMORY cycles before ready (w≥0; ready in the first MEMORY cycle gives w=0).
- **Cycle counter.** `cycles` increments every cycle `busy`=1, wraps at 2^`CNT_W`.

Test Plan:
- Reset, `start`=1, `single_step`=1, `opcode` of ADD `002081B3`, `instr_valid`=1 → enables FETCH, DECODE, EXEC, WB in cycles 1-4; `pc_we`=1 with `pc_sel`=0 in cycle 5; IDLE; `retired`=1, `cycles`=5.
- LD `0080B103`, `dmem_ready` asserted on the 3rd MEMORY cycle → `mem_req` high 3 cycles, then WB, then PCUPD; total 8 cycles; `stat`=00.
- BEQ `02208063` with `branch_taken`=1 → no `wb_en`; `pc_we`=1 and `pc_sel`=1 in cycle 4. Repeat with `branch_taken`=0 → `pc_sel`=0.
- SD `0020B823`, `dmem_ready` never asserted → after 15 MEMORY cycles, ERROR with `stat`=10, `busy`=0; `start` has no effect afterwards.
- Opcode `12345678`, `instr_valid`=0 → ERROR, `stat`=11, `retired` unchanged. `imem_error`=1 with `instr_valid`=0 → `stat`=10.
- ECALL `00000073` → HALT, `stat`=01, `retired` unchanged. Assert `rst` during MEMORY of a load → next cycle IDLE, all outputs 0, counters 0.

Source files
------------

// File: rtl/seq_stage_controller.sv
// -----------------------------------------------------------------------------
// seq_stage_controller
// Control FSM for the sequential RV64 core. One instruction at a time moves
// through FETCH, DECODE, EXECUTE, (MEMORY), (WB) and PCUPD. Every output is a
// registered decode of the next state, so it lines up exactly with the state
// register.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   start             leave IDLE and begin execution
//   single_step       return to IDLE after each retired instruction
//   instr_valid       fetch decoded a legal instruction
//   imem_error        fetch PC outside instruction memory
//   opcode[6:0]       opcode from fetch
//   branch_taken      execute resolved a taken branch/jump
//   dmem_ready        data memory completes the current access
//   dmem_error        data memory fault, qualified by dmem_ready
//   fetch_en, decode_en, exec_en, wb_en   one-cycle stage enables
//   mem_req           data memory request, high for every MEMORY cycle
//   pc_we, pc_sel     PC write strobe and source (1 = branch target)
//   busy              high outside IDLE/HALT/ERROR
//   stat[1:0]         00 AOK, 01 HLT, 10 ADR, 11 INS
//   retired, cycles   retired-instruction count, busy-cycle count
// -----------------------------------------------------------------------------
module seq_stage_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             single_step,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             dmem_ready,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             wb_en,
    output logic             mem_req,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             busy,
    output logic [1:0]       stat,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM    = 4'd4,
        ST_WB     = 4'd5,
        ST_PCUPD  = 4'd6,
        ST_HALT   = 4'd7,
        ST_ERROR  = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JUMP   = 3'd4,
        CLS_SYSTEM = 3'd5
    } cls_t;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    // Anything not recognised (including LUI and AUIPC) is handled as ALU.
    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            7'b0000011: classify = CLS_LOAD;
            7'b0100011: classify = CLS_STORE;
            7'b1100011: classify = CLS_BRANCH;
            7'b1101111: classify = CLS_JUMP;
            7'b1100111: classify = CLS_JUMP;
            7'b1110011: classify = CLS_SYSTEM;
            default:    classify = CLS_ALU;
        endcase
    endfunction

    state_t            state_r, next_state_s;
    cls_t              cls_r, cls_next_s;
    logic              pc_sel_r, pc_sel_next_s;
    logic [1:0]        stat_r, stat_next_s;
    logic [WAIT_W-1:0] wait_r, wait_next_s;
    logic              fetch_en_r, decode_en_r, exec_en_r, wb_en_r;
    logic              mem_req_r, pc_we_r, busy_r;
    logic [CNT_W-1:0]  retired_r, cycles_r;

    // Next-state, latched class, PC source, status and memory wait counter.
    always_comb begin
        next_state_s  = state_r;
        cls_next_s    = cls_r;
        pc_sel_next_s = pc_sel_r;
        stat_next_s   = stat_r;
        wait_next_s   = wait_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_FETCH;
                else       next_state_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (imem_error) begin
                    next_state_s = ST_ERROR;
                    stat_next_s  = STAT_ADR;
                end else if (!instr_valid) begin
                    next_state_s = ST_ERROR;
                    stat_next_s  = STAT_INS;
                end else begin
                    next_state_s = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cls_next_s = classify(opcode);
                if (classify(opcode) == CLS_SYSTEM) begin
                    next_state_s = ST_HALT;
                    stat_next_s  = STAT_HLT;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls_r == CLS_BRANCH || cls_r == CLS_JUMP) pc_sel_next_s = branch_taken;
                else                                          pc_sel_next_s = 1'b0;
                case (cls_r)
                    CLS_LOAD, CLS_STORE: next_state_s = ST_MEM;
                    CLS_BRANCH:          next_state_s = ST_PCUPD;
                    default:             next_state_s = ST_WB;
                endcase
            end
            ST_MEM: begin
                // Ready on the final allowed cycle still completes the access.
                if (dmem_ready) begin
                    wait_next_s = {WAIT_W{1'b0}};
                    if (dmem_error) begin
                        next_state_s = ST_ERROR;
                        stat_next_s  = STAT_ADR;
                    end else if (cls_r == CLS_LOAD) begin
                        next_state_s = ST_WB;
                    end else begin
                        next_state_s = ST_PCUPD;
                    end
                end else if (wait_r == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    wait_next_s  = {WAIT_W{1'b0}};
                    next_state_s = ST_ERROR;
                    stat_next_s  = STAT_ADR;
                end else begin
                    wait_next_s = wait_r + {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WB: begin
                next_state_s = ST_PCUPD;
            end
            ST_PCUPD: begin
                pc_sel_next_s = 1'b0;
                if (single_step) next_state_s = ST_IDLE;
                else             next_state_s = ST_FETCH;
            end
            ST_HALT:  next_state_s = ST_HALT;
            ST_ERROR: next_state_s = ST_ERROR;
            default: begin
                next_state_s = ST_ERROR;
                stat_next_s  = STAT_ADR;
            end
        endcase
    end

    // State, latched context and registered output decodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cls_r       <= CLS_ALU;
            pc_sel_r    <= 1'b0;
            stat_r      <= STAT_AOK;
            wait_r      <= {WAIT_W{1'b0}};
            fetch_en_r  <= 1'b0;
            decode_en_r <= 1'b0;
            exec_en_r   <= 1'b0;
            wb_en_r     <= 1'b0;
            mem_req_r   <= 1'b0;
            pc_we_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cls_r       <= cls_next_s;
            pc_sel_r    <= pc_sel_next_s;
            stat_r      <= stat_next_s;
            wait_r      <= wait_next_s;
            fetch_en_r  <= (next_state_s == ST_FETCH);
            decode_en_r <= (next_state_s == ST_DECODE);
            exec_en_r   <= (next_state_s == ST_EXEC);
            wb_en_r     <= (next_state_s == ST_WB);
            mem_req_r   <= (next_state_s == ST_MEM);
            pc_we_r     <= (next_state_s == ST_PCUPD);
            busy_r      <= !(next_state_s == ST_IDLE || next_state_s == ST_HALT ||
                             next_state_s == ST_ERROR);
        end
    end

    // Retired-instruction and busy-cycle counters, both free-wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_r <= {CNT_W{1'b0}};
            cycles_r  <= {CNT_W{1'b0}};
        end else begin
            if (state_r == ST_PCUPD) retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            else                     retired_r <= retired_r;
            if (busy_r) cycles_r <= cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
            else        cycles_r <= cycles_r;
        end
    end

    assign fetch_en  = fetch_en_r;
    assign decode_en = decode_en_r;
    assign exec_en   = exec_en_r;
    assign wb_en     = wb_en_r;
    assign mem_req   = mem_req_r;
    assign pc_we     = pc_we_r;
    assign pc_sel    = pc_sel_r;
    assign busy      = busy_r;
    assign stat      = stat_r;
    assign retired   = retired_r;
    assign cycles    = cycles_r;

endmodule

// File: tb/tb_seq_stage_controller.sv
// -----------------------------------------------------------------------------
// Testbench for seq_stage_controller. The reference model builds, for each
// instruction, the list of stages it must visit (from its opcode class, the
// fetch status and the memory wait), then walks that list cycle by cycle
// comparing the stage enables, status and counters.
// -----------------------------------------------------------------------------
module tb_seq_stage_controller;

    localparam int CNT_W = 32;
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_P = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, single_step, instr_valid, imem_error;
    logic [6:0]       opcode;
    logic             branch_taken, dmem_ready, dmem_error;
    logic             fetch_en, decode_en, exec_en, wb_en, mem_req, pc_we, pc_sel, busy;
    logic [1:0]       stat;
    logic [CNT_W-1:0] retired, cycles;

    int errors = 0;
    int checks = 0;
    int exp_retired = 0;
    int exp_cycles  = 0;

    seq_stage_controller #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .single_step(single_step),
        .instr_valid(instr_valid), .imem_error(imem_error), .opcode(opcode),
        .branch_taken(branch_taken), .dmem_ready(dmem_ready), .dmem_error(dmem_error),
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en),
        .mem_req(mem_req), .pc_we(pc_we), .pc_sel(pc_sel), .busy(busy),
        .stat(stat), .retired(retired), .cycles(cycles)
    );

    wire [7:0] obs_vec = {fetch_en, decode_en, exec_en, mem_req, wb_en, pc_we, pc_sel, busy};

    // Expected {fetch,decode,exec,mem_req,wb,pc_we,pc_sel,busy} for a stage.
    function automatic logic [7:0] vec_of(input int ph, input logic sel);
        case (ph)
            P_F:     vec_of = 8'b1000_0001;
            P_D:     vec_of = 8'b0100_0001;
            P_E:     vec_of = 8'b0010_0001;
            P_M:     vec_of = {6'b000100, sel, 1'b1};
            P_W:     vec_of = {6'b000010, sel, 1'b1};
            P_P:     vec_of = {6'b000001, sel, 1'b1};
            default: vec_of = 8'b0000_0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset(input string name);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_retired = 0;
        exp_cycles  = 0;
        chk({name, " reset outputs"}, 64'(obs_vec), 64'd0);
        chk({name, " reset stat"},    64'(stat), 64'd0);
        chk({name, " reset retired"}, 64'(retired), 64'd0);
        chk({name, " reset cycles"},  64'(cycles), 64'd0);
    endtask

    // w: MEMORY cycles before ready (-1 = never). rst_at: trace index at
    // which reset is asserted (-1 = none). DUT must be in IDLE on entry.
    task automatic exec_instr(input string name, input logic [31:0] instr,
                              input bit valid, input bit ierr, input bit taken,
                              input int w, input bit derr, input bit step,
                              input int rst_at);
        int         ph[$];
        bit         term;
        bit         ctl;
        logic [1:0] tstat;
        logic [6:0] op;
        int         mcnt;
        int         nmem;
        logic       sel;
        op    = instr[6:0];
        term  = 1'b0;
        tstat = 2'b00;
        ctl   = (op == 7'b1100011) || (op == 7'b1101111) || (op == 7'b1100111);
        // Reference: list of stages this instruction must visit.
        ph.push_back(P_F);
        if (ierr) begin
            term = 1'b1; tstat = 2'b10;
        end else if (!valid) begin
            term = 1'b1; tstat = 2'b11;
        end else begin
            ph.push_back(P_D);
            if (op == 7'b1110011) begin
                term = 1'b1; tstat = 2'b01;
            end else begin
                ph.push_back(P_E);
                if (op == 7'b0000011 || op == 7'b0100011) begin
                    nmem = (w < 0 || w >= 15) ? 15 : w + 1;
                    for (int k = 0; k < nmem; k++) ph.push_back(P_M);
                    if (w < 0 || w >= 15 || derr) begin
                        term = 1'b1; tstat = 2'b10;
                    end else begin
                        if (op == 7'b0000011) ph.push_back(P_W);
                        ph.push_back(P_P);
                    end
                end else if (op == 7'b1100011) begin
                    ph.push_back(P_P);
                end else begin
                    ph.push_back(P_W);
                    ph.push_back(P_P);
                end
            end
        end

        opcode       = op;
        instr_valid  = valid;
        imem_error   = ierr;
        branch_taken = taken;
        single_step  = step;
        dmem_ready   = 1'b0;
        dmem_error   = 1'b0;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mcnt  = 0;
        foreach (ph[i]) begin
            if (ph[i] == P_M) begin
                dmem_ready = (mcnt == w);
                dmem_error = (mcnt == w) ? derr : 1'($urandom_range(0, 1));
                mcnt++;
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_error = 1'($urandom_range(0, 1));
            end
            sel = ctl && taken && (ph[i] == P_M || ph[i] == P_W || ph[i] == P_P);
            chk($sformatf("%s stage[%0d]", name, i), 64'(obs_vec), 64'(vec_of(ph[i], sel)));
            if (i == rst_at) begin
                do_reset({name, " mid"});
                return;
            end
            @(posedge clk); #1;
        end
        dmem_ready = 1'b0;
        dmem_error = 1'b0;
        exp_cycles += ph.size();
        if (ph[ph.size()-1] == P_P) exp_retired++;
        chk({name, " retired"}, 64'(retired), 64'(exp_retired));
        chk({name, " cycles"},  64'(cycles),  64'(exp_cycles));
        chk({name, " stat"},    64'(stat),    64'(tstat));
        if (term) begin
            chk({name, " stopped"}, 64'(obs_vec), 64'd0);
            start = 1'b1;
            repeat (3) begin @(posedge clk); #1; end
            start = 1'b0;
            chk({name, " sticky outputs"}, 64'(obs_vec), 64'd0);
            chk({name, " sticky stat"},    64'(stat), 64'(tstat));
            chk({name, " sticky retired"}, 64'(retired), 64'(exp_retired));
            do_reset(name);
        end else if (step) begin
            chk({name, " idle"}, 64'(obs_vec), 64'd0);
        end else begin
            chk({name, " refetch"}, 64'(obs_vec), 64'(vec_of(P_F, 1'b0)));
            do_reset(name);
        end
    endtask

    initial begin
        logic [6:0]  ops [8];
        logic [31:0] rnd;
        logic [31:0] instr;
        int          w;
        ops[0] = 7'b0110011; ops[1] = 7'b0000011; ops[2] = 7'b0100011; ops[3] = 7'b1100011;
        ops[4] = 7'b1101111; ops[5] = 7'b1100111; ops[6] = 7'b1110011; ops[7] = 7'b0110111;
        rst = 1'b1; start = 1'b0; single_step = 1'b1; instr_valid = 1'b0;
        imem_error = 1'b0; opcode = 7'd0; branch_taken = 1'b0;
        dmem_ready = 1'b0; dmem_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("init");

        // Directed scenarios.
        exec_instr("add",       32'h002081B3, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b1, -1);
        exec_instr("ld_w2",     32'h0080B103, 1'b1, 1'b0, 1'b0,  2, 1'b0, 1'b1, -1);
        exec_instr("ld_w0",     32'h0080B103, 1'b1, 1'b0, 1'b1,  0, 1'b0, 1'b1, -1);
        exec_instr("beq_t",     32'h02208063, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1, -1);
        exec_instr("beq_nt",    32'h02208063, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b1, -1);
        exec_instr("jal_t",     32'h0000006F, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1, -1);
        exec_instr("sd_w14",    32'h0020B823, 1'b1, 1'b0, 1'b0, 14, 1'b0, 1'b1, -1);
        exec_instr("sd_nordy",  32'h0020B823, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b1, -1);
        exec_instr("sd_derr",   32'h0020B823, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b1, -1);
        exec_instr("illegal",   32'h12345678, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1, -1);
        exec_instr("imem_err",  32'h12345678, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b1, -1);
        exec_instr("add_pre",   32'h002081B3, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b1, -1);
        exec_instr("ecall",     32'h00000073, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b1, -1);
        exec_instr("ld_rst",    32'h0080B103, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b1,  4);
        exec_instr("add_cont",  32'h002081B3, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0, -1);

        // Randomized instruction mix.
        for (int n = 0; n < 40; n++) begin
            rnd   = $urandom();
            instr = {rnd[31:7], ops[$urandom_range(0, 7)]};
            w     = $urandom_range(0, 19);
            if (w > 16) w = -1;
            exec_instr($sformatf("rnd%0d", n), instr,
                       ($urandom_range(0, 15) != 0), ($urandom_range(0, 15) == 0),
                       1'($urandom_range(0, 1)), w, ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 3) != 0), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
